// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-key 4-state
// debounce FSM, registered level, press/release pulses and optional auto-repeat.
module key_debounce #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("key_debounce: REPEAT_RATE must be >= 1");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [1:0]    sync_q;
        logic          raw;
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, press_q, release_q;
        logic          level_d, press_d, release_d;

        // Synchronizer presets to "released" so a key held through reset
        // is seen as a fresh press once reset lifts.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q <= 2'b11;
            else          sync_q <= {sync_q[0], key_n[i]};
        end

        assign raw = ~sync_q[1];

        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                RELEASED: begin
                    if (raw) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!raw) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!raw) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (raw) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;

        if (REPEAT_DELAY > 0) begin : g_repeat
            localparam int            RW        = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
            localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
            localparam logic [RW-1:0] RPT_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

            logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
            logic          repeat_q, repeat_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rpt_q    <= '0;
                    repeat_q <= 1'b0;
                end else begin
                    rpt_q    <= rpt_d;
                    repeat_q <= repeat_d;
                end
            end

            // Counter folds back to the first-pulse point after each period,
            // so an indefinite hold never overflows it.
            always_comb begin
                rpt_inc  = rpt_q + RW'(1);
                rpt_d    = rpt_q;
                repeat_d = 1'b0;
                if (press_d) begin
                    rpt_d = '0;
                end else if (state_q == PRESSED && state_d == PRESSED) begin
                    repeat_d = (rpt_inc == RPT_FIRST) || (rpt_inc == RPT_WRAP);
                    rpt_d    = (rpt_inc == RPT_WRAP) ? RPT_FIRST : rpt_inc;
                end
            end

            assign key_repeat[i] = repeat_q;
        end else begin : g_no_repeat
            assign key_repeat[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized scoreboard bench for key_debounce: a run-length reference model
// predicts every output cycle; a monitor compares the DUT against the queue.
module tb_key_debounce;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat)
    );

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rpt;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cycle    = 0;
    bit     running  = 1'b1;
    logic   prev_rn  = 1'b0;

    // Reference model: synchronizer delay line, accepted level, length of the
    // current run of samples disagreeing with it, and cycles spent held.
    bit     m_s1[NK], m_s2[NK], m_lvl[NK];
    int     m_run[NK];
    longint m_hold[NK];

    task automatic check(input string name, input logic [4*NK-1:0] act, input logic [4*NK-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    task automatic model_edge(input logic rn, input logic [NK-1:0] kn, output exp_t e);
        e = '0;
        for (int i = 0; i < NK; i++) begin
            if (!rn) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
                m_run[i] = 0;   m_hold[i] = 0;
            end else begin
                bit raw, held_steady;
                raw = ~m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = kn[i];
                held_steady = m_lvl[i] && (m_run[i] == 0);
                if (raw != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = raw;
                        m_run[i] = 0;
                        e.press[i] = raw;
                        e.rel[i]   = !raw;
                        if (raw) m_hold[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (held_steady && raw) begin
                    m_hold[i]++;
                    if (RD > 0 && (m_hold[i] == RD ||
                        (m_hold[i] > RD && (m_hold[i] - RD) % RR == 0)))
                        e.rpt[i] = 1'b1;
                end
                e.level[i] = m_lvl[i];
            end
        end
    endtask

    task automatic step(input logic rn, input logic [NK-1:0] kn);
        exp_t e;
        reset_n = rn;
        key_n   = kn;
        if (!rn && prev_rn) begin
            #1;
            check("async_reset", {key_level, key_press, key_release, key_repeat}, '0);
        end
        prev_rn = rn;
        model_edge(rn, kn, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic rn, input logic [NK-1:0] kn, input int n);
        for (int k = 0; k < n; k++) step(rn, kn);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("outputs@%0d", cycle),
                      {key_level, key_press, key_release, key_repeat}, e);
            end else if (running) begin
                n_checks++;
                $display("FAIL scoreboard_empty@%0d: got no expectation, expected one", cycle);
            end
        end
    end

    initial begin : driver
        int dur[NK];
        logic [NK-1:0] kn;

        hold(1'b0, 2'b11, 3);
        hold(1'b1, 2'b11, 3);
        // single press held long enough for several repeats, then release
        hold(1'b1, 2'b10, 30);
        hold(1'b1, 2'b11, 12);
        // too-short glitch
        hold(1'b1, 2'b10, 3);
        hold(1'b1, 2'b11, 10);
        // bounce then settle
        hold(1'b1, 2'b10, 2);
        hold(1'b1, 2'b11, 1);
        hold(1'b1, 2'b10, 14);
        hold(1'b1, 2'b11, 10);
        // both keys together, release one
        hold(1'b1, 2'b00, 12);
        hold(1'b1, 2'b01, 10);
        hold(1'b1, 2'b11, 10);
        // reset while held
        hold(1'b1, 2'b10, 12);
        hold(1'b0, 2'b10, 2);
        hold(1'b1, 2'b10, 12);
        hold(1'b1, 2'b11, 10);

        kn = '1;
        for (int i = 0; i < NK; i++) dur[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    kn[i]  = ~kn[i];
                    dur[i] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(5, 40));
                end
            end
            if ($urandom_range(0, 399) == 0) hold(1'b0, kn, int'($urandom_range(1, 3)));
            else                             step(1'b1, kn);
        end
        hold(1'b1, 2'b11, 12);

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz); legal range >= 2.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000: cycles held before the first auto-repeat pulse; 0 disables auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 5000000: cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port key_n, input, NUM_KEYS: raw, asynchronous, bouncy, active-low push-buttons.
REQ-008 SHALL have port key_level, output, NUM_KEYS: debounced level, active-high (1 = pressed), suitable for a PIO in_port.
REQ-009 SHALL have port key_press, output, NUM_KEYS: one-cycle pulse on an accepted press.
REQ-010 SHALL have port key_release, output, NUM_KEYS: one-cycle pulse on an accepted release.
REQ-011 SHALL have port key_repeat, output, NUM_KEYS: one-cycle auto-repeat pulse while held.

Function
REQ-012 SHALL pass each key_n bit through a two-flop synchronizer and invert it to form raw[i] (1 = pressed); raw is valid after the 2nd clock edge that samples key_n.
REQ-013 SHALL run one independent 4-state FSM per key: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; keys never interact.
REQ-014 RELEASED: raw=1 -> PRESS_WAIT with count=1; otherwise stay.
REQ-015 PRESS_WAIT: raw=0 -> RELEASED, count cleared, no pulse; raw=1 and count=DEBOUNCE_CYCLES-1 -> PRESSED; else count+1.
REQ-016 PRESSED: raw=0 -> RELEASE_WAIT with count=1; otherwise stay.
REQ-017 RELEASE_WAIT: raw=1 -> PRESSED, no pulse; raw=0 and count=DEBOUNCE_CYCLES-1 -> RELEASED; else count+1.
REQ-018 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1) and it SHALL never wrap.
REQ-019 key_level[i] SHALL be registered, equal to 1 in PRESSED and RELEASE_WAIT and 0 otherwise.
REQ-020 Total press latency: key_level rises on clock edge DEBOUNCE_CYCLES+2, counting as edge 1 the first edge that samples key_n low, with key_n held low throughout; release latency is symmetric.
REQ-021 key_press[i] SHALL be 1 for exactly the cycle following the PRESS_WAIT->PRESSED edge, i.e. coincident with the first cycle of key_level=1.
REQ-022 key_release[i] SHALL be 1 for exactly the cycle following the RELEASE_WAIT->RELEASED edge.
REQ-023 Repeat counter SHALL clear on entry to PRESSED from PRESS_WAIT, increment each cycle in PRESSED, and freeze in RELEASE_WAIT (resume on bounce back to PRESSED).
REQ-024 First key_repeat pulse SHALL occur REPEAT_DELAY cycles after the key_press pulse, then every REPEAT_RATE cycles while in PRESSED.
REQ-025 key_repeat SHALL never assert in RELEASED or PRESS_WAIT, nor in the same cycle as key_press; repeat counters SHALL not overflow during an indefinite hold.
REQ-026 With REPEAT_DELAY=0, key_repeat SHALL be constant 0.
REQ-027 Simultaneous press of several keys SHALL produce pulses on the same cycle if their raw inputs are identical.

Reset
REQ-028 reset_n=0 SHALL immediately (asynchronously) force all outputs to 0, all FSMs to RELEASED, all counters to 0, and synchronizer flops to 1 (released).
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard all state; no pulse SHALL be emitted by reset itself.
REQ-030 A key held low through reset deassertion SHALL be treated as a new press: key_press after the full REQ-020 latency.

Verification (NUM_KEYS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3)
REQ-031 key_n[0] driven low before edge 1 and held -> key_level[0]=1 after edge 6, key_press[0]=1 for that one cycle only, key[1] outputs stay 0.
REQ-032 key_n[0] low for 3 cycles then high -> key_level, key_press, key_release all remain 0.
REQ-033 Bounce low 2/high 1/low held -> key_level rises 4 samples after the final low transition reaches raw; exactly one key_press pulse.
REQ-034 Hold after press -> key_repeat[0] pulses 8 cycles after key_press, then at +3, +6, ...; release (key_n high held) -> key_level falls after 6 edges with one key_release pulse and no further key_repeat.
REQ-035 Both keys pressed same cycle -> key_press=2'b11 in one cycle; release key[1] only -> key_level=2'b01.
REQ-036 reset_n pulsed low while key[0] in PRESSED and still held -> outputs 0 during reset; after deassertion key_press[0] fires after 6 edges.
